// File: rtl/mtimer_pkg.sv
// mtimer_pkg: shared definitions for the memory-mapped machine timer.
//   - byte offsets of every register in the 32-byte window
//   - CTRL bit positions and the ctrl_t register layout
//   - word-select decode helper used by the read/write decoders
package mtimer_pkg;

    localparam logic [4:0] MTIME_LO_OFF    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFF    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF        = 5'h10;
    localparam logic [4:0] PRESCALE_OFF    = 5'h14;
    localparam logic [4:0] RELOAD_OFF      = 5'h18;

    localparam int unsigned CNT_EN_BIT = 0;
    localparam int unsigned IRQ_EN_BIT = 1;

    typedef struct packed {
        logic irq_en;
        logic cnt_en;
    } ctrl_t;

    // Registers are word aligned; addr[1:0] never takes part in decode.
    function automatic logic [2:0] word_idx(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// mtimer_prescaler: programmable divider producing the mtime advance strobe.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; counter holds when low
//   reload   : terminal count; tick period is reload+1 enabled cycles
//   clr      : synchronous clear of the counter (prescale reprogram)
//   tick     : one-cycle strobe when the counter sits at the terminal count
module mtimer_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] reload,
    input  logic         clr,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en & (cnt == reload);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mtimer_irq_gen.sv
// mtimer_irq_gen: memory-mapped machine timer and interrupt source.
//   clk, rst        : clock, asynchronous active-high reset
//   sel             : address decode hit for this peripheral
//   rd_en, wr_en    : MEM-stage read / write strobes
//   addr            : byte offset, addr[4:2] selects the register
//   wdata           : write data
//   rdata           : combinational read data (0 when not reading)
//   timer_interrupt : registered level interrupt, irq_en & (mtime >= mtimecmp)
// Build option: define MTIMER_AUTO_RELOAD_EN to map RELOAD at 0x18 and
// advance mtimecmp by RELOAD on each rising match (periodic interrupt).
module mtimer_irq_gen
    import mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter logic [63:0] RST_CMP    = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    ctrl_t                 ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic                  tick;
    logic                  match;
    logic                  wr;
    logic                  rd;
    logic [2:0]            idx;
    logic                  unused_addr_lsbs;

    assign wr               = sel & wr_en;
    assign rd               = sel & rd_en;
    assign idx              = addr[4:2];
    assign unused_addr_lsbs = ^addr[1:0];
    assign match            = (mtime >= mtimecmp);

    mtimer_prescaler #(
        .W(PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl.cnt_en),
        .reload (prescale),
        .clr    (wr && idx == word_idx(PRESCALE_OFF)),
        .tick   (tick)
    );

    // A software write to either half takes priority over the tick increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (wr && idx == word_idx(MTIME_LO_OFF)) begin
            mtime[31:0] <= wdata;
        end else if (wr && idx == word_idx(MTIME_HI_OFF)) begin
            mtime[63:32] <= wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

`ifdef MTIMER_AUTO_RELOAD_EN
    logic [31:0] reload;
    logic        match_q;
    logic        reload_fire;

    assign reload_fire = match & ~match_q & (reload != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= match;
            if (wr && idx == word_idx(RELOAD_OFF)) begin
                reload <= wdata;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= RST_CMP;
        end else if (wr && idx == word_idx(MTIMECMP_LO_OFF)) begin
            mtimecmp[31:0] <= wdata;
        end else if (wr && idx == word_idx(MTIMECMP_HI_OFF)) begin
            mtimecmp[63:32] <= wdata;
`ifdef MTIMER_AUTO_RELOAD_EN
        end else if (reload_fire) begin
            mtimecmp <= mtimecmp + {32'd0, reload};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            prescale <= '0;
        end else if (wr) begin
            if (idx == word_idx(CTRL_OFF)) begin
                ctrl.cnt_en <= wdata[CNT_EN_BIT];
                ctrl.irq_en <= wdata[IRQ_EN_BIT];
            end
            if (idx == word_idx(PRESCALE_OFF)) begin
                prescale <= wdata[PRESCALE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= ctrl.irq_en & match;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (idx)
                word_idx(MTIME_LO_OFF):    rdata = mtime[31:0];
                word_idx(MTIME_HI_OFF):    rdata = mtime[63:32];
                word_idx(MTIMECMP_LO_OFF): rdata = mtimecmp[31:0];
                word_idx(MTIMECMP_HI_OFF): rdata = mtimecmp[63:32];
                word_idx(CTRL_OFF): begin
                    rdata[CNT_EN_BIT] = ctrl.cnt_en;
                    rdata[IRQ_EN_BIT] = ctrl.irq_en;
                end
                word_idx(PRESCALE_OFF):    rdata = 32'(prescale);
`ifdef MTIMER_AUTO_RELOAD_EN
                word_idx(RELOAD_OFF):      rdata = reload;
`endif
                default:                   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// tb_mtimer_irq_gen: directed bench for mtimer_irq_gen with a behavioural
// model compared against rdata and timer_interrupt every cycle, plus
// hand-computed expectations at the key points of each scenario.
module tb_mtimer_irq_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        rd_en;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timer_interrupt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mtimer_irq_gen #(
        .PRESCALE_W (16),
        .RST_CMP    (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sel             (sel),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .timer_interrupt (timer_interrupt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [63:0] m_time    = 64'd0;
    logic [63:0] m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_cnt_en  = 1'b0;
    logic        m_irq_en  = 1'b0;
    logic [15:0] m_pre     = 16'd0;
    logic [15:0] m_pc      = 16'd0;
    logic        m_irq     = 1'b0;
    logic        m_match_p = 1'b0;
    logic [31:0] m_reload  = 32'd0;

    always @(posedge clk or posedge rst) begin
        logic       w;
        logic [2:0] i;
        logic       tk;
        logic       mt;
        if (rst) begin
            m_time = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_cnt_en = 1'b0; m_irq_en = 1'b0; m_pre = 16'd0; m_pc = 16'd0;
            m_irq = 1'b0; m_match_p = 1'b0; m_reload = 32'd0;
        end else begin
            w  = sel && wr_en;
            i  = addr[4:2];
            tk = m_cnt_en && (m_pc == m_pre);
            mt = (m_time >= m_cmp);
            m_irq = m_irq_en && mt;
            if ((w && i == 3'd5) || tk) m_pc = 16'd0;
            else if (m_cnt_en)          m_pc = m_pc + 16'd1;
            if (w && i == 3'd0)      m_time = {m_time[63:32], wdata};
            else if (w && i == 3'd1) m_time = {wdata, m_time[31:0]};
            else if (tk)             m_time = m_time + 64'd1;
            if (w && i == 3'd2)      m_cmp = {m_cmp[63:32], wdata};
            else if (w && i == 3'd3) m_cmp = {wdata, m_cmp[31:0]};
`ifdef MTIMER_AUTO_RELOAD_EN
            else if (mt && !m_match_p && m_reload != 32'd0)
                m_cmp = m_cmp + {32'd0, m_reload};
            if (w && i == 3'd6) m_reload = wdata;
`endif
            m_match_p = mt;
            if (w && i == 3'd4) begin
                m_cnt_en = wdata[0];
                m_irq_en = wdata[1];
            end
            if (w && i == 3'd5) m_pre = wdata[15:0];
        end
    end

    function automatic logic [31:0] model_read();
        if (!(sel && rd_en)) return 32'd0;
        case (addr[4:2])
            3'd0: return m_time[31:0];
            3'd1: return m_time[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_irq_en, m_cnt_en};
            3'd5: return {16'd0, m_pre};
`ifdef MTIMER_AUTO_RELOAD_EN
            3'd6: return m_reload;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("model_rdata", rdata, model_read());
        chk("model_irq", {31'd0, timer_interrupt}, {31'd0, m_irq});
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic s, input logic r, input logic w,
                         input logic [4:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        sel = s; rd_en = r; wr_en = w; addr = a; wdata = d;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'h00, 32'd0);
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        drive(1'b1, 1'b1, 1'b0, a, 32'd0);
        @(negedge clk);
        chk(name, rdata, exp);
    endtask

    task automatic irq_chk(input logic exp, input string name);
        idle();
        @(negedge clk);
        chk(name, {31'd0, timer_interrupt}, {31'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        rd_chk(5'h00, 32'h0000_0000, "rst_mtime_lo");
        rd_chk(5'h04, 32'h0000_0000, "rst_mtime_hi");
        rd_chk(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd_chk(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd_chk(5'h1C, 32'h0000_0000, "unmapped_1c");
        chk("rst_irq", {31'd0, timer_interrupt}, 32'd0);

        // Prescale 3: one tick every 4 enabled cycles
        wr(5'h14, 32'd3);
        wr(5'h10, 32'h1);
        repeat (39) idle();
        rd_chk(5'h00, 32'd9,  "presc_e39");
        rd_chk(5'h00, 32'd10, "presc_e40");
        idle();
        idle();
        rd_chk(5'h00, 32'd10, "presc_e43");
        rd_chk(5'h00, 32'd11, "presc_e44");
        rd_chk(5'h14, 32'd3,  "prescale_rb");

        // Carry into HI, then full 64-bit wrap
        wr(5'h10, 32'h0);
        wr(5'h14, 32'd0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h1);
        rd_chk(5'h00, 32'hFFFF_FFFF, "carry_pre");
        rd_chk(5'h00, 32'h0000_0000, "carry_lo");
        rd_chk(5'h04, 32'h0000_0001, "carry_hi");
        wr(5'h10, 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h10, 32'h1);
        rd_chk(5'h04, 32'hFFFF_FFFF, "wrap_pre_hi");
        rd_chk(5'h00, 32'h0000_0000, "wrap_lo");
        rd_chk(5'h04, 32'h0000_0000, "wrap_hi");

        // Interrupt at mtime 20, cleared by raising mtimecmp
        wr(5'h10, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h10, 32'h3);
        rd_chk(5'h10, 32'h3, "ctrl_rb");
        repeat (19) idle();
        irq_chk(1'b0, "irq_at_20");
        irq_chk(1'b1, "irq_at_21");
        idle();
        idle();
        irq_chk(1'b1, "irq_hold");
        wr(5'h08, 32'd100);
        irq_chk(1'b1, "irq_lat_drop");
        irq_chk(1'b0, "irq_dropped");

        // Same-cycle read/write returns old value; write suppresses the tick
        drive(1'b1, 1'b1, 1'b1, 5'h00, 32'h55);
        @(negedge clk);
        chk("rw_old", rdata, 32'd28);
        rd_chk(5'h00, 32'h55, "rw_new");
        drive(1'b0, 1'b1, 1'b1, 5'h00, 32'h1234);
        @(negedge clk);
        chk("nosel_rdata", rdata, 32'd0);
        rd_chk(5'h00, 32'h57, "nosel_nochange");

        // Asynchronous reset mid-operation drops the interrupt at once
        wr(5'h08, 32'h50);
        idle();
        irq_chk(1'b1, "irq_before_rst");
        #2 rst = 1'b1;
        #1 chk("irq_async_rst", {31'd0, timer_interrupt}, 32'd0);
        rd_chk(5'h00, 32'd0, "rst_mid_lo");
        @(posedge clk);
        #1 rst = 1'b0;
        rd_chk(5'h08, 32'hFFFF_FFFF, "rst_mid_cmp");
        rd_chk(5'h10, 32'h0, "rst_mid_ctrl");

`ifdef MTIMER_AUTO_RELOAD_EN
        // Periodic single-cycle pulses at mtime 10, 20, 30
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd10);
        wr(5'h18, 32'd10);
        wr(5'h14, 32'd0);
        wr(5'h10, 32'h3);
        for (int unsigned i = 0; i < 34; i++) begin
            irq_chk((i == 11 || i == 21 || i == 31), "reload_pulse");
        end
        rd_chk(5'h08, 32'd40, "reload_cmp");
        rd_chk(5'h18, 32'd10, "reload_rb");
`else
        rd_chk(5'h18, 32'd0, "unmapped_18");
`endif

        idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
